// File: rtl/mem_access_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage.
// Optional misaligned-access trapping is built with MEM_MISALIGN_TRAP_EN.
package mem_access_stage_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   localparam logic [1:0] MASK_B = 2'b00;
   localparam logic [1:0] MASK_H = 2'b01;
   localparam logic [1:0] MASK_W = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // Any mask code other than B or H is handled as a word access.
   function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] addr_lo);
      logic bad;
      case (mask)
         MASK_B:  bad = 1'b0;
         MASK_H:  bad = addr_lo[0];
         default: bad = (addr_lo != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_stage_lane.sv
// Combinational byte-lane steering: store data replication, byte enables,
// and load-lane extraction with sign/zero extension.
module mem_lane_align #(
   parameter int XLEN = 32
) (
   input  logic [1:0]      mask,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   input  logic            unsigned_load,
   output logic [XLEN-1:0] wdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] load_data
);
   import mem_access_stage_pkg::*;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      wdata     = store_data;
      be        = 4'b1111;
      load_data = rdata;
      case (mask)
         MASK_B: begin
            wdata     = {4{store_data[7:0]}};
            be        = 4'b0001 << addr_lo;
            load_data = unsigned_load ? {{(XLEN-8){1'b0}}, byte_sel}
                                      : {{(XLEN-8){byte_sel[7]}}, byte_sel};
         end
         MASK_H: begin
            wdata     = {2{store_data[15:0]}};
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            load_data = unsigned_load ? {{(XLEN-16){1'b0}}, half_sel}
                                      : {{(XLEN-16){half_sel[15]}}, half_sel};
         end
         default: begin
            wdata     = store_data;
            be        = 4'b1111;
            load_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory request/ack handshake, pipeline stall, MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and pulse misalign_trap.
module mem_access_stage #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] alu_res_mem,
   input  logic [XLEN-1:0] bypass_op2_mem,
   input  logic [RAW-1:0]  rd_addr_mem,
   input  logic            mem_read_mem,
   input  logic            mem_write_mem,
   input  logic [1:0]      mask_mem,
   input  logic            unsigned_load_mem,
   input  logic            reg_write_mem,
   input  logic            mem_to_reg_mem,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_mem,
   output logic [XLEN-1:0] wb_data_wb,
   output logic [RAW-1:0]  rd_addr_wb,
   output logic            reg_write_wb,
   output logic            misalign_trap
);
   import mem_access_stage_pkg::*;

   // state | meaning
   // IDLE  | no outstanding bus transaction; a new access requests immediately
   // WAIT  | request issued, not yet acked; pipeline frozen so inputs are stable

   mem_state_t state_q, state_d;

   logic            access;
   logic            misalign;
   logic            access_eff;
   logic [XLEN-1:0] load_data;

   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic [RAW-1:0]  rd_addr_q, rd_addr_d;
   logic            reg_write_q, reg_write_d;

   assign access = mem_read_mem | mem_write_mem;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_trap_q, misalign_trap_d;

   assign misalign        = access & is_misaligned(mask_mem, alu_res_mem[1:0]);
   assign misalign_trap_d = misalign;
   assign misalign_trap   = misalign_trap_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_trap_q <= 1'b0;
      end else begin
         misalign_trap_q <= misalign_trap_d;
      end
   end
`else
   assign misalign      = 1'b0;
   assign misalign_trap = 1'b0;
`endif

   assign access_eff = access & ~misalign;

   mem_lane_align #(
      .XLEN (XLEN)
   ) u_lane (
      .mask          (mask_mem),
      .addr_lo       (alu_res_mem[1:0]),
      .store_data    (bypass_op2_mem),
      .rdata         (dmem_rdata),
      .unsigned_load (unsigned_load_mem),
      .wdata         (dmem_wdata),
      .be            (dmem_be),
      .load_data     (load_data)
   );

   always_comb begin
      state_d  = state_q;
      dmem_req = 1'b0;
      case (state_q)
         IDLE: begin
            dmem_req = access_eff;
            if (access_eff && !dmem_ack) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Store wins when read and write are both set; load data is then discarded by mem_to_reg upstream.
   assign dmem_we   = dmem_req & mem_write_mem;
   assign dmem_addr = {alu_res_mem[XLEN-1:2], 2'b00};
   assign stall_mem = access_eff & ~dmem_ack;

   always_comb begin
      wb_data_d   = wb_data_q;
      rd_addr_d   = rd_addr_q;
      reg_write_d = 1'b0;
      if (!stall_mem) begin
         wb_data_d   = mem_to_reg_mem ? load_data : alu_res_mem;
         rd_addr_d   = rd_addr_mem;
         reg_write_d = reg_write_mem & ~misalign;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wb_data_q   <= '0;
         rd_addr_q   <= '0;
         reg_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wb_data_q   <= wb_data_d;
         rd_addr_q   <= rd_addr_d;
         reg_write_q <= reg_write_d;
      end
   end

   assign wb_data_wb   = wb_data_q;
   assign rd_addr_wb   = rd_addr_q;
   assign reg_write_wb = reg_write_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage sitting directly downstream of the EX/MEM register.
- Turns address, store data and control bits into a request/acknowledge transaction on the data-memory bus.
- Aligns store data into byte lanes and extracts/extends load data.
- Generates the pipeline stall while memory is busy and holds the MEM/WB register feeding writeback.

Parameters:
- XLEN, 32, data/address width (equals REG_DATA_WIDTH)
- RAW, 5, register address width (equals REG_ADDR_WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alu_res_mem  in  XLEN  effective address, or ALU result for non-memory ops
- bypass_op2_mem  in  XLEN  store data
- rd_addr_mem  in  RAW  destination register
- mem_read_mem  in  1  load
- mem_write_mem  in  1  store
- mask_mem  in  2  access size: MASK_B / MASK_H / MASK_W
- unsigned_load_mem  in  1  zero-extend load
- reg_write_mem  in  1  writeback enable
- mem_to_reg_mem  in  1  writeback source is memory
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- dmem_wdata  out  XLEN  lane-aligned store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  transaction complete; rdata valid the same cycle for reads
- dmem_rdata  in  XLEN  read word
- stall_mem  out  1  freeze IF..EX/MEM
- wb_data_wb  out  XLEN  registered writeback data
- rd_addr_wb  out  RAW  registered destination register
- reg_write_wb  out  1  registered writeback enable
- misalign_trap  out  1  misaligned-access pulse (feature only)

Behaviour:
- access = mem_read_mem | mem_write_mem.
- FSM states: IDLE, WAIT.
  - IDLE, access=1: dmem_req=1 combinationally in the same cycle. If dmem_ack=1, the access completes with no stall. Otherwise go to WAIT.
  - WAIT: dmem_req held at 1; addr, we, be and wdata held stable (inputs are frozen by the stall). On dmem_ack, go to IDLE.
- stall_mem = access & ~dmem_ack, in either state.
- Store lanes:
  - B: wdata = byte replicated ×4; be = 4'b0001 << addr[1:0].
  - H: wdata = halfword replicated ×2; be = addr[1] ? 4'b1100 : 4'b0011.
  - W: wdata = data; be = 4'b1111.
- Loads: dmem_be is driven exactly as for a store of the same size. The byte/half lane is selected by addr[1:0]. Sign-extend, or zero-extend when unsigned_load_mem=1. W passes through.
- MEM/WB register updates on every clk:
  - stall_mem=1: inserts a bubble (reg_write_wb=0; rd_addr_wb and wb_data_wb hold).
  - Otherwise: wb_data_wb = mem_to_reg_mem ? extended_load : alu_res_mem; rd_addr_wb = rd_addr_mem; reg_write_wb = reg_write_mem.
- Latency: writeback data is valid 1 cycle after the ack cycle (or after the non-memory cycle).
- Simultaneous mem_read and mem_write: the store has priority (we=1) and load data is not used. Upstream must never produce this combination.
- dmem_ack while dmem_req=0 is ignored.
- Reset:
  - FSM → IDLE.
  - wb_data_wb=0, rd_addr_wb=0, reg_write_wb=0, misalign_trap=0.
  - Reset mid-WAIT abandons the transaction. The memory side must tolerate request withdrawal.
- x0: rd_addr=0 with reg_write=1 passes through unchanged; the register file ignores it.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - H with addr[0]=1, or W with addr[1:0]!=0, issues no dmem_req and no stall.
  - reg_write_wb is forced to 0.
  - misalign_trap is a registered 1-cycle pulse in the following cycle.
- Not defined:
  - Low address bits below the access size are ignored (H uses addr[1], W uses lane 0).
  - misalign_trap is tied to 0.

Decomposition:
- Shared package: MASK_B=2'b00, MASK_H=2'b01, MASK_W=2'b10; state enum {IDLE, WAIT}; XLEN/RAW constants.
- One sub-module, mem_lane_align: purely combinational store-lane/be generation plus load extraction/extension. The FSM and MEM/WB register stay in the top module.

Test Plan:
- SB addr=0x1003, data=0x000000AB, ack in the same cycle → be=4'b1000, wdata=0xABABABAB, stall_mem never asserted.
- LB addr=0x2001, rdata=0x0000F000, ack after 3 cycles → stall_mem high 3 cycles, reg_write_wb bubbles; then wb_data_wb=0xFFFFFFF0. Same with unsigned_load=1 → 0x000000F0.
- LH addr=0x2002, rdata=0x80010000 → wb_data_wb=0xFFFF8001, be=4'b1100.
- ALU op, result 0x12345678, rd=7 → no dmem_req; next cycle wb_data_wb=0x12345678, rd_addr_wb=7, reg_write_wb=1.
- rst asserted during WAIT → next cycle dmem_req=0, stall_mem=0, all wb outputs 0.
- With MEM_MISALIGN_TRAP_EN: LW addr=0x3002 → no dmem_req, misalign_trap=1 for 1 cycle, reg_write_wb=0.
